des_des_pipe_param: RTL and testbench

//  Parametrised DES datapath: IP -> 16 Feistel rounds -> inverse IP, grouped into STAGES

---
 rtl/des_des_pipe_param.sv | 187 ++++++++++++++++++
 tb/tb_des_des_pipe_param.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/des_des_pipe_param.sv
// Parametrised DES datapath: IP -> 16 Feistel rounds -> inverse IP, in 16/ROUNDS_PER_STAGE stages.
// Optional DES_DEBUG_TAP_EN macro adds the selected_out {L,R} debug tap mux.
module des_des_pipe_param #(
    parameter int ROUNDS_PER_STAGE = 1,
    parameter int TAG_W            = 4
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [0:63]       input_block,
    input  logic              decrypt,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic [0:15][0:47] round_keys,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [0:63]       output_block,
    output logic [TAG_W-1:0]  out_tag,
    output logic              busy,
    input  logic [4:0]        round_select,
    output logic [0:63]       selected_out
);
    localparam int STAGES = 16 / ROUNDS_PER_STAGE;

    localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                                 62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                                 57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                                 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                                 38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                                 36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                                 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
    localparam int E_T [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                                16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
    localparam int P_T [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                                2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
    // Each S-box is stored row-major: entry = row*16 + column.
    localparam int SBOX [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
          4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
          0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
          13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
          10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
          4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
          9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
          1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
          7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

    function automatic logic [0:63] ip_perm(input logic [0:63] d);
        logic [0:63] o;
        for (int i = 0; i < 64; i++) o[i] = d[IP_T[i]-1];
        return o;
    endfunction

    function automatic logic [0:63] fp_perm(input logic [0:63] d);
        logic [0:63] o;
        for (int i = 0; i < 64; i++) o[i] = d[FP_T[i]-1];
        return o;
    endfunction

    function automatic logic [0:31] feistel(input logic [0:31] r, input logic [0:47] k);
        logic [0:47] x;
        logic [0:31] s;
        logic [0:31] o;
        logic [0:5]  b;
        logic [5:0]  idx;
        for (int i = 0; i < 48; i++) x[i] = r[E_T[i]-1] ^ k[i];
        for (int bx = 0; bx < 8; bx++) begin
            b   = x[bx*6 +: 6];
            idx = {b[0], b[5], b[1:4]};
            s[bx*4 +: 4] = 4'(SBOX[bx][idx]);
        end
        for (int i = 0; i < 32; i++) o[i] = s[P_T[i]-1];
        return o;
    endfunction

    // Key direction follows the block's own decrypt bit, so mixed streams need no flush.
    function automatic logic [0:63] run_rounds(input logic [0:31] l_in, input logic [0:31] r_in,
                                               input logic dec, input int first,
                                               input logic [0:15][0:47] keys);
        logic [0:31] l;
        logic [0:31] r;
        logic [0:31] t;
        int          kidx;
        l = l_in;
        r = r_in;
        for (int j = 0; j < ROUNDS_PER_STAGE; j++) begin
            kidx = first + j;
            t = l ^ feistel(r, dec ? keys[15-kidx] : keys[kidx]);
            l = r;
            r = t;
        end
        return {l, r};
    endfunction

    logic [0:63]      ip_blk;
    logic [0:31]      src_l   [STAGES];
    logic [0:31]      src_r   [STAGES];
    logic             src_dec [STAGES];
    logic             src_vld [STAGES];
    logic [TAG_W-1:0] src_tag [STAGES];
    logic [0:63]      nxt     [STAGES];
    logic [0:31]      st_l    [STAGES];
    logic [0:31]      st_r    [STAGES];
    logic             st_dec  [STAGES];
    logic             st_vld  [STAGES];
    logic [TAG_W-1:0] st_tag  [STAGES];
    logic             advance;
    logic             unused_last_dec;

    assign ip_blk = ip_perm(input_block);

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        if (g == 0) begin : g_first
            assign src_l[g]   = ip_blk[0:31];
            assign src_r[g]   = ip_blk[32:63];
            assign src_dec[g] = decrypt;
            assign src_tag[g] = in_tag;
            assign src_vld[g] = in_valid;
        end else begin : g_next
            assign src_l[g]   = st_l[g-1];
            assign src_r[g]   = st_r[g-1];
            assign src_dec[g] = st_dec[g-1];
            assign src_tag[g] = st_tag[g-1];
            assign src_vld[g] = st_vld[g-1];
        end
        assign nxt[g] = run_rounds(src_l[g], src_r[g], src_dec[g], g * ROUNDS_PER_STAGE, round_keys);
    end

    // Handshake: a block moves when valid && ready on the same rising edge. The whole pipe
    // advances together whenever the output slot is empty or being consumed; bubbles stay in place.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int s = 0; s < STAGES; s++) begin
                st_vld[s] <= 1'b0;
                st_dec[s] <= 1'b0;
                st_tag[s] <= '0;
                st_l[s]   <= '0;
                st_r[s]   <= '0;
            end
        end else if (advance) begin
            for (int s = 0; s < STAGES; s++) begin
                st_vld[s] <= src_vld[s];
                st_dec[s] <= src_dec[s];
                st_tag[s] <= src_tag[s];
                st_l[s]   <= nxt[s][0:31];
                st_r[s]   <= nxt[s][32:63];
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int s = 0; s < STAGES; s++) busy = busy | st_vld[s];
    end

    // Final swap: the inverse IP takes R16||L16.
    assign out_valid       = st_vld[STAGES-1];
    assign output_block    = fp_perm({st_r[STAGES-1], st_l[STAGES-1]});
    assign out_tag         = st_tag[STAGES-1];
    assign unused_last_dec = st_dec[STAGES-1];

`ifdef DES_DEBUG_TAP_EN
    always_comb begin
        selected_out = 64'h0;
        if (round_select == 5'd0) selected_out = ip_blk;
        for (int s = 0; s < STAGES; s++) begin
            if (round_select == 5'(s + 1)) selected_out = {st_l[s], st_r[s]};
        end
    end
`else
    logic unused_round_select;
    assign selected_out        = 64'h0;
    assign unused_round_select = ^round_select;
`endif

endmodule

// File: tb/tb_des_des_pipe_param.sv
// Directed bench for des_des_pipe_param using the classic DES vector K=133457799BBCDFF1.
module tb_des_des_pipe_param;
    parameter int RPS = 1;
    localparam int STAGES = 16 / RPS;
    localparam int TAG_W  = 4;
    localparam logic [63:0] PT = 64'h0123456789ABCDEF;
    localparam logic [63:0] CT = 64'h85E813540F0AB405;

    logic              clk = 1'b0;
    logic              n_rst;
    logic              in_valid;
    logic              in_ready;
    logic [0:63]       in_block;
    logic              decrypt;
    logic [TAG_W-1:0]  in_tag;
    logic [0:15][0:47] round_keys;
    logic              out_valid;
    logic              out_ready;
    logic [0:63]       output_block;
    logic [TAG_W-1:0]  out_tag;
    logic              busy;
    logic [4:0]        round_select;
    logic [0:63]       selected_out;

    int checks   = 0;
    int failures = 0;
    logic [63:0]      exp_q[$];
    logic [TAG_W-1:0] tag_q[$];

    des_des_pipe_param #(.ROUNDS_PER_STAGE(RPS), .TAG_W(TAG_W)) dut (
        .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready),
        .input_block(in_block), .decrypt(decrypt), .in_tag(in_tag), .round_keys(round_keys),
        .out_valid(out_valid), .out_ready(out_ready), .output_block(output_block),
        .out_tag(out_tag), .busy(busy), .round_select(round_select), .selected_out(selected_out)
    );

    always #5 clk = ~clk;

    task automatic test_reset;
        n_rst = 1'b0; in_valid = 1'b0; in_block = '0; decrypt = 1'b0; in_tag = '0;
        out_ready = 1'b0; round_select = 5'd0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (output_block !== 64'h0) begin failures++; $display("FAIL rst_output_block got=%h exp=0", output_block); end
        checks++; if (out_tag !== 4'h0) begin failures++; $display("FAIL rst_out_tag got=%h exp=0", out_tag); end
        @(negedge clk); n_rst = 1'b1; #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
        checks++; if (selected_out !== 64'h0) begin failures++; $display("FAIL rst_selected_out got=%h exp=0", selected_out); end
    endtask

    task automatic test_encrypt;
        int lat = -1;
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; in_block = PT; decrypt = 1'b0; in_tag = 4'd5;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL enc_in_ready got=%b exp=1", in_ready); end
        for (int n = 1; n <= STAGES + 4; n++) begin
            @(negedge clk); in_valid = 1'b0; #1;
            if (out_valid === 1'b1 && lat < 0) begin
                lat = n;
                checks++; if (output_block !== CT) begin failures++; $display("FAIL enc_data got=%h exp=%h", output_block, CT); end
                checks++; if (out_tag !== 4'd5) begin failures++; $display("FAIL enc_tag got=%h exp=5", out_tag); end
            end
        end
        checks++; if (lat != STAGES) begin failures++; $display("FAIL enc_latency got=%0d exp=%0d", lat, STAGES); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL enc_busy_idle got=%b exp=0", busy); end
    endtask

    task automatic test_interleave;
        int got = 0;
        int out_c [2] = '{-1, -1};
        logic [63:0] ed;
        logic [TAG_W-1:0] et;
        exp_q.delete(); tag_q.delete();
        for (int c = 0; c < STAGES + 6; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = (c < 2);
            in_block  = (c == 1) ? CT : PT;
            decrypt   = (c == 1);
            in_tag    = (c == 1) ? 4'd2 : 4'd1;
            #1;
            if (in_valid && in_ready) begin
                exp_q.push_back(decrypt ? PT : CT); tag_q.push_back(in_tag);
            end
            if (out_valid && out_ready) begin
                if (got < 2) out_c[got] = c;
                got++;
                if (exp_q.size() == 0) begin
                    checks++; failures++; $display("FAIL mix_extra got=%h exp=none", output_block);
                end else begin
                    ed = exp_q.pop_front(); et = tag_q.pop_front();
                    checks++; if (output_block !== ed) begin failures++; $display("FAIL mix_data got=%h exp=%h", output_block, ed); end
                    checks++; if (out_tag !== et) begin failures++; $display("FAIL mix_tag got=%h exp=%h", out_tag, et); end
                end
            end
        end
        checks++; if (got != 2) begin failures++; $display("FAIL mix_count got=%0d exp=2", got); end
        checks++; if (out_c[0] != STAGES) begin failures++; $display("FAIL mix_first_cycle got=%0d exp=%0d", out_c[0], STAGES); end
        checks++; if (out_c[1] != out_c[0] + 1) begin failures++; $display("FAIL mix_consecutive got=%0d exp=%0d", out_c[1], out_c[0] + 1); end
    endtask

    task automatic test_backpressure;
        int got = 0;
        int stall = 0;
        logic blk4 = 1'b0;
        logic [63:0] ed;
        logic [TAG_W-1:0] et;
        exp_q.delete(); tag_q.delete();
        for (int c = 0; c < 200 && got < 4; c++) begin
            @(negedge clk);
            if (c < 3) begin
                in_valid = 1'b1; in_block = (c == 1) ? CT : PT; decrypt = (c == 1); in_tag = TAG_W'(c + 3);
            end else begin
                in_valid = !blk4; in_block = CT; decrypt = 1'b1; in_tag = 4'd7;
            end
            out_ready = (c < 3) || (stall >= 10);
            #1;
            if (in_valid && in_ready) begin
                exp_q.push_back(decrypt ? PT : CT); tag_q.push_back(in_tag);
                if (c >= 3) blk4 = 1'b1;
            end
            if (out_valid && !out_ready && exp_q.size() > 0) begin
                stall++;
                checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
                checks++; if (output_block !== exp_q[0]) begin failures++; $display("FAIL bp_hold_data got=%h exp=%h", output_block, exp_q[0]); end
                checks++; if (out_tag !== tag_q[0]) begin failures++; $display("FAIL bp_hold_tag got=%h exp=%h", out_tag, tag_q[0]); end
            end
            if (out_valid && out_ready) begin
                got++;
                if (exp_q.size() == 0) begin
                    checks++; failures++; $display("FAIL bp_extra got=%h exp=none", output_block);
                end else begin
                    ed = exp_q.pop_front(); et = tag_q.pop_front();
                    checks++; if (output_block !== ed) begin failures++; $display("FAIL bp_data got=%h exp=%h", output_block, ed); end
                    checks++; if (out_tag !== et) begin failures++; $display("FAIL bp_tag got=%h exp=%h", out_tag, et); end
                end
            end
        end
        in_valid = 1'b0;
        checks++; if (got != 4) begin failures++; $display("FAIL bp_count got=%0d exp=4", got); end
        checks++; if (stall != 10) begin failures++; $display("FAIL bp_stall_cycles got=%0d exp=10", stall); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL bp_leftover got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_throughput;
        int got = 0;
        int sent = 0;
        int first_c = -1;
        int last_c = -1;
        logic [63:0] ed;
        logic [TAG_W-1:0] et;
        exp_q.delete(); tag_q.delete();
        for (int c = 0; c < 32 + STAGES + 8; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = (sent < 32);
            decrypt   = sent[0];
            in_block  = sent[0] ? CT : PT;
            in_tag    = TAG_W'(sent);
            #1;
            if (in_valid && in_ready) begin
                exp_q.push_back(decrypt ? PT : CT); tag_q.push_back(in_tag); sent++;
            end
            if (out_valid && out_ready) begin
                if (got == 0) first_c = c;
                last_c = c;
                got++;
                if (exp_q.size() == 0) begin
                    checks++; failures++; $display("FAIL thr_extra got=%h exp=none", output_block);
                end else begin
                    ed = exp_q.pop_front(); et = tag_q.pop_front();
                    checks++; if (output_block !== ed) begin failures++; $display("FAIL thr_data got=%h exp=%h", output_block, ed); end
                    checks++; if (out_tag !== et) begin failures++; $display("FAIL thr_tag got=%h exp=%h", out_tag, et); end
                end
            end
        end
        in_valid = 1'b0;
        checks++; if (got != 32) begin failures++; $display("FAIL thr_count got=%0d exp=32", got); end
        checks++; if (first_c != STAGES) begin failures++; $display("FAIL thr_first got=%0d exp=%0d", first_c, STAGES); end
        checks++; if (last_c - first_c != 31) begin failures++; $display("FAIL thr_span got=%0d exp=31", last_c - first_c); end
    endtask

    task automatic test_reset_midflight;
        int got = 0;
        int lat = -1;
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            in_valid = 1'b1; in_block = PT; decrypt = 1'b0; in_tag = TAG_W'(c);
        end
        @(negedge clk); in_valid = 1'b0; #1;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rmf_busy_before got=%b exp=1", busy); end
        @(negedge clk); n_rst = 1'b0; #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rmf_out_valid got=%b exp=0", out_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmf_busy got=%b exp=0", busy); end
        checks++; if (output_block !== 64'h0) begin failures++; $display("FAIL rmf_output_block got=%h exp=0", output_block); end
        checks++; if (out_tag !== 4'h0) begin failures++; $display("FAIL rmf_out_tag got=%h exp=0", out_tag); end
        @(negedge clk);
        n_rst = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_block = PT; decrypt = 1'b0; in_tag = 4'd9;
        for (int n = 1; n <= STAGES + 6; n++) begin
            @(negedge clk); in_valid = 1'b0; #1;
            if (out_valid === 1'b1) begin
                got++;
                if (lat < 0) lat = n;
                checks++; if (output_block !== CT) begin failures++; $display("FAIL rmf_data got=%h exp=%h", output_block, CT); end
                checks++; if (out_tag !== 4'd9) begin failures++; $display("FAIL rmf_tag got=%h exp=9", out_tag); end
            end
        end
        checks++; if (got != 1) begin failures++; $display("FAIL rmf_count got=%0d exp=1", got); end
        checks++; if (lat != STAGES) begin failures++; $display("FAIL rmf_latency got=%0d exp=%0d", lat, STAGES); end
    endtask

`ifdef DES_DEBUG_TAP_EN
    // Stage-1 value below is the state after round 1, i.e. one round per stage.
    task automatic test_tap;
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; in_block = PT; decrypt = 1'b0; in_tag = 4'd1; round_select = 5'd0;
        #1;
        checks++; if (selected_out !== 64'hCC00CCFF_F0AAF0AA) begin failures++; $display("FAIL tap_ip got=%h exp=CC00CCFFF0AAF0AA", selected_out); end
        @(negedge clk); in_valid = 1'b0; round_select = 5'd1; #1;
        checks++; if (selected_out !== 64'hF0AAF0AA_EF4A6544) begin failures++; $display("FAIL tap_stage1 got=%h exp=F0AAF0AAEF4A6544", selected_out); end
        round_select = 5'd20; #1;
        checks++; if (selected_out !== 64'h0) begin failures++; $display("FAIL tap_out_of_range got=%h exp=0", selected_out); end
        round_select = 5'd0;
        repeat (STAGES + 2) @(negedge clk);
    endtask
`endif

    initial begin
        round_keys = {48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
                      48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
                      48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
                      48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};
        test_reset();
        test_encrypt();
        test_interleave();
        test_backpressure();
        test_throughput();
        test_reset_midflight();
`ifdef DES_DEBUG_TAP_EN
        test_tap();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
